store_buffer: RTL

//  Write-side counterpart of the cached load path: queues CPU stores and drains them to data_mem

---
 rtl/store_buffer_pkg.sv | 14 +
 rtl/store_buffer_fifo.sv | 45 ++++
 rtl/store_buffer.sv | 96 +++++++++
 3 files changed

// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: entry layout, size codes and drain states shared by the store buffer and its bench.
package store_buffer_pkg;
  localparam int SB_AW = 32;
  localparam int SB_DW = 32;
  localparam logic [2:0] MC_SB = 3'b000;
  localparam logic [2:0] MC_SH = 3'b001;
  localparam logic [2:0] MC_SW = 3'b010;
  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
    logic [2:0]       memcontrol;
  } sb_entry_t;
  typedef enum logic {SB_IDLE, SB_ISSUE} sb_state_e;
endpackage

// File: rtl/store_buffer_fifo.sv
// store_buffer_fifo: circular entry array with head/tail/count, exposing every slot and its pending bit.
module store_buffer_fifo #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [AW-1:0]                in_addr,
  input  logic [DW-1:0]                in_data,
  input  logic [2:0]                   in_mc,
  output logic [DEPTH-1:0][AW-1:0]     addrs,
  output logic [DEPTH-1:0][DW-1:0]     datas,
  output logic [DEPTH-1:0][2:0]        mcs,
  output logic [DEPTH-1:0]             valid,
  output logic [PW-1:0]                head,
  output logic [CW-1:0]                count
);
  logic [PW-1:0] tail;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      addrs <= '0;
      datas <= '0;
      mcs   <= '0;
    end else begin
      if (push) begin
        addrs[tail] <= in_addr;
        datas[tail] <= in_data;
        mcs[tail]   <= in_mc;
        tail        <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  // a slot is pending when its age (distance from head) is below count
  always_comb
    for (int i = 0; i < DEPTH; i++) valid[i] = CW'(PW'(i) - head) < count;
endmodule

// File: rtl/store_buffer.sv
// store_buffer: queues CPU stores and drains them to data_mem when no load holds the port.
// Define STORE_FWD_EN to forward data from the youngest matching full-word store.
module store_buffer import store_buffer_pkg::*; #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDRESS_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0]    st_data,
  input  logic [2:0]               st_memcontrol,
  input  logic                     mem_busy,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  output logic [2:0]               mem_memcontrol,
  input  logic [ADDRESS_WIDTH-1:0] ld_addr,
  output logic                     ld_conflict,
  output logic                     ld_fwd_hit,
  output logic [DATA_WIDTH-1:0]    ld_fwd_data,
  output logic                     empty,
  output logic [CW-1:0]            count
);
  logic [DEPTH-1:0][ADDRESS_WIDTH-1:0] addrs;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]    datas;
  logic [DEPTH-1:0][2:0]               mcs;
  logic [DEPTH-1:0]                    valid;
  logic [PW-1:0]                       head;
  logic [PW-1:0]                       idx;
  logic                                push, pop, legal, remain, hit, hit_sw;
  logic [DATA_WIDTH-1:0]               hit_data;
  logic                                unused_ld_bits;
  sb_state_e                           state, state_next;

  assign legal    = st_memcontrol == MC_SB || st_memcontrol == MC_SH || st_memcontrol == MC_SW;
  assign st_ready = count != CW'(DEPTH);
  assign empty    = count == '0;
  assign push     = st_valid && st_ready && legal;
  assign pop      = state == SB_ISSUE;

  store_buffer_fifo #(.AW(ADDRESS_WIDTH), .DW(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .in_addr(st_addr), .in_data(st_data), .in_mc(st_memcontrol),
    .addrs(addrs), .datas(datas), .mcs(mcs), .valid(valid), .head(head), .count(count)
  );

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= SB_IDLE;
    else      state <= state_next;

  // an issuing write always commits, so back-to-back issue only looks at what is left after it
  always_comb begin
    remain     = (count - CW'(pop) + CW'(push)) != '0;
    state_next = !mem_busy && (pop ? remain : !empty) ? SB_ISSUE : SB_IDLE;
  end

  assign mem_we         = state == SB_ISSUE;
  assign mem_a          = addrs[head];
  assign mem_wd         = datas[head];
  assign mem_memcontrol = mcs[head];

  // walk oldest to youngest so the last match seen is the youngest
  always_comb begin
    idx      = '0;
    hit      = 1'b0;
    hit_sw   = 1'b0;
    hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (valid[idx] && addrs[idx][ADDRESS_WIDTH-1:2] == ld_addr[ADDRESS_WIDTH-1:2]) begin
        hit      = 1'b1;
        hit_sw   = mcs[idx] == MC_SW;
        hit_data = datas[idx];
      end
    end
  end

  assign unused_ld_bits = ^ld_addr[1:0];

`ifdef STORE_FWD_EN
  assign ld_fwd_hit  = hit && hit_sw;
  assign ld_fwd_data = ld_fwd_hit ? hit_data : '0;
  assign ld_conflict = hit && !hit_sw;
`else
  logic unused_fwd;
  assign unused_fwd  = hit_sw ^ ^hit_data;
  assign ld_fwd_hit  = 1'b0;
  assign ld_fwd_data = '0;
  assign ld_conflict = hit;
`endif
endmodule
